// File: rtl/axi_slice_pkg.sv
// Shared encodings for the AXI register slice: mode selectors and the skid FSM state.
// State bits are chosen so that m_valid and s_ready come straight off state flops.
package axi_slice_pkg;

  localparam int MODE_BYPASS = 0;
  localparam int MODE_FWD    = 1;
  localparam int MODE_FULL   = 2;

  // bit1 = s_ready, bit0 = m_valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b10,
    ST_ONE   = 2'b11,
    ST_FULL  = 2'b01
  } slice_state_e;

  function automatic logic [1:0] state_count(slice_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dff_async_rst_n.sv
// Enable flip-flop with asynchronous active-low reset to a parameterised value.
module dff_async_rst_n #(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      q_o <= RESET;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/axi_reg_slice.sv
// Valid/ready register slice: bypass, forward-registered, or full skid buffer,
// selected at elaboration by MODE.
module axi_reg_slice
  import axi_slice_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               MODE       = MODE_FULL,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
  input  logic             i_clock,
  input  logic             i_areset_n,
  input  logic             i_flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       o_count
);

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("axi_reg_slice: WIDTH must be 1..1024");
  end

  if (MODE == MODE_BYPASS) begin : g_bypass
    logic unused_ok;

    assign m_valid   = s_valid;
    assign m_data    = s_data;
    assign s_ready   = m_ready;
    assign o_count   = 2'd0;
    assign unused_ok = &{1'b0, i_clock, i_areset_n, i_flush};

  end else if (MODE == MODE_FWD) begin : g_fwd
    logic             valid_q;
    logic             valid_d;
    logic             accept;
    logic [WIDTH-1:0] data_q;

    assign s_ready = !valid_q | m_ready;
    // A beat offered during flush is dropped even though s_ready may be high.
    assign accept  = s_valid & s_ready & !i_flush;

    always_comb begin
      valid_d = valid_q;
      if (i_flush) begin
        valid_d = 1'b0;
      end else if (accept) begin
        valid_d = 1'b1;
      end else if (m_ready) begin
        valid_d = 1'b0;
      end
    end

    dff_async_rst_n #(.WIDTH(1), .RESET(1'b0)) u_valid (
      .clk_i    (i_clock),
      .arst_n_i (i_areset_n),
      .en_i     (1'b1),
      .d_i      (valid_d),
      .q_o      (valid_q)
    );

    dff_async_rst_n #(.WIDTH(WIDTH), .RESET(RESET_DATA)) u_data (
      .clk_i    (i_clock),
      .arst_n_i (i_areset_n),
      .en_i     (accept),
      .d_i      (s_data),
      .q_o      (data_q)
    );

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign o_count = {1'b0, valid_q};

  end else if (MODE == MODE_FULL) begin : g_full
    logic [1:0]       state_bits_q;
    slice_state_e     state_q;
    slice_state_e     state_d;
    logic             accept;
    logic             out_en;
    logic             out_from_skid;
    logic             skid_en;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] skid_q;

    assign state_q = slice_state_e'(state_bits_q);
    assign s_ready = state_bits_q[1];
    assign m_valid = state_bits_q[0];
    assign accept  = s_valid & s_ready;

    always_comb begin
      state_d       = state_q;
      out_en        = 1'b0;
      out_from_skid = 1'b0;
      skid_en       = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_en  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !m_ready) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (accept) begin
            out_en  = 1'b1;
          end else if (m_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (m_ready) begin
            state_d       = ST_ONE;
            out_en        = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Flush overrides any handshake and leaves data registers untouched.
      if (i_flush) begin
        state_d = ST_EMPTY;
        out_en  = 1'b0;
        skid_en = 1'b0;
      end
    end

    assign out_d = out_from_skid ? skid_q : s_data;

    dff_async_rst_n #(.WIDTH(2), .RESET(ST_EMPTY)) u_state (
      .clk_i    (i_clock),
      .arst_n_i (i_areset_n),
      .en_i     (1'b1),
      .d_i      (state_d),
      .q_o      (state_bits_q)
    );

    dff_async_rst_n #(.WIDTH(WIDTH), .RESET(RESET_DATA)) u_out (
      .clk_i    (i_clock),
      .arst_n_i (i_areset_n),
      .en_i     (out_en),
      .d_i      (out_d),
      .q_o      (out_q)
    );

    dff_async_rst_n #(.WIDTH(WIDTH), .RESET(RESET_DATA)) u_skid (
      .clk_i    (i_clock),
      .arst_n_i (i_areset_n),
      .en_i     (skid_en),
      .d_i      (s_data),
      .q_o      (skid_q)
    );

    assign m_data  = out_q;
    assign o_count = state_count(state_q);

  end else begin : g_bad_mode
    $error("axi_reg_slice: MODE must be 0, 1 or 2");
  end

endmodule
